gru_sequencer: RTL
==================

# gru_sequencer

Sequencing stage wrapped around `gruCell`. It accepts one input frame x_t per timestep over a valid/ready handshake and holds the recurrent hidden-state register. It drives the cell's `x_t` and `h_t_minus_1` inputs, captures the cell's `h_t` after a fixed pipeline latency, and feeds it back for the next step. After `SEQ_LEN` steps it presents the final hidden state downstream to the dense/classifier layer and clears the state for the next sequence.

## Interface
Parameters:
- `WIDTH`, 32, data word width; signed fixed point.
- `NFRAC`, 10, fractional bits. Pass-through only; the block does no arithmetic on data.
- `x_SIZE`, 32, input vector length d.
- `h_SIZE`, 32, hidden vector length e.
- `SEQ_LEN`, 8, timesteps per sequence; ≥1.
- `CELL_LATENCY`, 3, cycles from stable cell inputs to valid `cell_h_t`; ≥1.

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `reset`, in, 1, synchronous active-high reset.
- `x_valid`, in, 1, upstream frame valid.
- `x_ready`, out, 1, block can accept a frame.
- `x_data`, in, signed [WIDTH-1:0] [0:x_SIZE-1], input frame.
- `cell_x_t`, out, signed [WIDTH-1:0] [0:x_SIZE-1], to `gruCell.x_t`.
- `cell_h_prev`, out, signed [WIDTH-1:0] [0:h_SIZE-1], to `gruCell.h_t_minus_1`.
- `cell_h_t`, in, signed [WIDTH-1:0] [0:h_SIZE-1], from `gruCell.h_t`.
- `cell_busy`, out, 1, high while the cell is computing (COMPUTE state).
- `h_valid`, out, 1, final hidden state valid.
- `h_ready`, in, 1, downstream accepts the final state.
- `h_data`, out, signed [WIDTH-1:0] [0:h_SIZE-1], final hidden state.
- `step`, out, $clog2(SEQ_LEN+1), timesteps completed in the current sequence.

## Operation
- State registers: `x_reg[x_SIZE]`, `h_state[h_SIZE]`, `step`, `lat_cnt`, FSM {ACCEPT, COMPUTE, OUTPUT}.
- Reset state: FSM=ACCEPT; `x_reg`, `h_state`, `step`, `lat_cnt` = 0. Resulting outputs: `x_ready`=1, `cell_busy`=0, `h_valid`=0, `h_data`=0, `cell_x_t`=0, `cell_h_prev`=0.
- ACCEPT:
  - `x_ready`=1.
  - On `x_valid && x_ready`: `x_reg`←`x_data`, `lat_cnt`←CELL_LATENCY, go to COMPUTE.
  - Without `x_valid`: hold.
- COMPUTE:
  - `x_ready`=0, `cell_busy`=1.
  - `cell_x_t`=`x_reg` and `cell_h_prev`=`h_state`, both held constant for the whole state.
  - `lat_cnt` decrements each cycle.
  - In the cycle with `lat_cnt`==1: `h_state`←`cell_h_t`, `step`←`step`+1.
  - Then go to OUTPUT if `step`+1==SEQ_LEN, else ACCEPT.
- OUTPUT:
  - `h_valid`=1, `h_data`=`h_state`, `x_ready`=0.
  - Hold until `h_ready`.
  - On `h_valid && h_ready`: `h_state`←0, `step`←0, go to ACCEPT.
- `cell_x_t` and `cell_h_prev` are driven from `x_reg`/`h_state` in every state. No combinational path from `x_data` to the cell.
- `h_data` = `h_state` in all states. It is only meaningful while `h_valid`=1.
- Data is never modified: no rounding, saturation or sign handling. Width and Q format follow WIDTH/NFRAC end to end.
- The first step of every sequence sees `cell_h_prev`=0, which is the initial hidden state.
- `reset` mid-COMPUTE or mid-OUTPUT: the partial sequence is discarded; all state returns to reset values on the next edge.
- `x_valid` while not in ACCEPT: ignored (`x_ready`=0). Upstream must hold the frame.
- SEQ_LEN=1: a single COMPUTE pass goes straight to OUTPUT.

## Timing
- Frame accepted at edge T. COMPUTE spans cycles T+1 … T+CELL_LATENCY. The capture edge ends cycle T+CELL_LATENCY.
- `x_ready` re-asserts in cycle T+CELL_LATENCY+1, giving a throughput of 1 frame per CELL_LATENCY+1 cycles.
- The cell contract is that `cell_h_t` is valid at the sampling edge closing the CELL_LATENCY-th cycle of stable inputs. CELL_LATENCY=1 supports a purely combinational cell.
- `h_valid` rises the cycle after the last capture edge.
- Sequence latency from first acceptance to `h_valid` = SEQ_LEN·(CELL_LATENCY+1) cycles, given back-to-back frames.
- `h_valid && h_ready` in cycle U: `x_ready`=1 in cycle U+1, and a new frame can be accepted at the edge ending U+1.

## Test plan
Bench setup: x_SIZE=2, h_SIZE=2, NFRAC=10, SEQ_LEN=3, CELL_LATENCY=3. The behavioural cell model is `cell_h_t` = `cell_h_prev` + `cell_x_t` (elementwise), delayed by 3 cycles.

- **Reset values:** assert reset 2 cycles -> `x_ready`=1, `h_valid`=0, `step`=0, `cell_h_prev`={0,0}.
- **Back-to-back frames:** frames {1024,2048}, {1024,-512}, {0,512}, `x_valid` held high, `h_ready`=1 -> `x_ready` pulses every 4 cycles; `h_valid` for 1 cycle 12 cycles after the first accept; `h_data`={2048,2048}.
- **Downstream backpressure:** `h_ready`=0 for 5 cycles -> `h_valid` and `h_data` stable; `x_valid`=1 shows `x_ready`=0 throughout.
- **Sequence restart:** a second sequence with frames {5,5} ×3 -> `h_data`={15,15}; first-step `cell_h_prev`={0,0}.
- **Reset mid-sequence:** reset asserted during step 2 COMPUTE -> next cycle `step`=0, `h_state`=0, `x_ready`=1; a following full sequence produces a correct result.
- **Input bubbles:** 7-cycle gaps on `x_valid` -> FSM waits in ACCEPT; `cell_h_prev` is unchanged during gaps; final result is identical to the back-to-back case.

Source files
------------

// File: rtl/gru_sequencer.sv
// +----------------------------------------------------------------------------+
// | gru_sequencer : timestep sequencer and hidden-state holder around gruCell   |
// | Revision 1.0 : initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gru_sequencer #(
   parameter int WIDTH        = 32,
   parameter int NFRAC        = 10,
   parameter int x_SIZE       = 32,
   parameter int h_SIZE       = 32,
   parameter int SEQ_LEN      = 8,
   parameter int CELL_LATENCY = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              x_valid,
   output logic                              x_ready,
   input  logic signed [WIDTH-1:0]           x_data      [0:x_SIZE-1],
   output logic signed [WIDTH-1:0]           cell_x_t    [0:x_SIZE-1],
   output logic signed [WIDTH-1:0]           cell_h_prev [0:h_SIZE-1],
   input  logic signed [WIDTH-1:0]           cell_h_t    [0:h_SIZE-1],
   output logic                              cell_busy,
   output logic                              h_valid,
   input  logic                              h_ready,
   output logic signed [WIDTH-1:0]           h_data      [0:h_SIZE-1],
   output logic [$clog2(SEQ_LEN+1)-1:0]      step
);

   localparam int STEP_W = $clog2(SEQ_LEN + 1);
   localparam int LAT_W  = $clog2(CELL_LATENCY + 1);

   localparam logic [STEP_W-1:0] c_seq_len  = STEP_W'(SEQ_LEN);
   localparam logic [STEP_W-1:0] c_step_one = STEP_W'(1);
   localparam logic [LAT_W-1:0]  c_lat_init = LAT_W'(CELL_LATENCY);
   localparam logic [LAT_W-1:0]  c_lat_one  = LAT_W'(1);

   if (NFRAC >= WIDTH || SEQ_LEN < 1 || CELL_LATENCY < 1) begin : g_param_check
      $error("gru_sequencer: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      S_ACCEPT  = 2'd0,
      S_COMPUTE = 2'd1,
      S_OUTPUT  = 2'd2
   } state_t;

   state_t                   r_state;
   logic signed [WIDTH-1:0]  r_x_reg   [0:x_SIZE-1];
   logic signed [WIDTH-1:0]  r_h_state [0:h_SIZE-1];
   logic [STEP_W-1:0]        r_step;
   logic [LAT_W-1:0]         r_lat_cnt;
   logic                     r_x_ready;
   logic                     r_cell_busy;
   logic                     r_h_valid;
   logic [STEP_W-1:0]        w_step_inc;

   assign w_step_inc = r_step + c_step_one;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_ACCEPT;
         r_x_reg     <= '{default: '0};
         r_h_state   <= '{default: '0};
         r_step      <= '0;
         r_lat_cnt   <= '0;
         r_x_ready   <= 1'b1;
         r_cell_busy <= 1'b0;
         r_h_valid   <= 1'b0;
      end else begin
         case (r_state)
            S_ACCEPT: begin
               if (x_valid) begin
                  r_x_reg     <= x_data;
                  r_lat_cnt   <= c_lat_init;
                  r_state     <= S_COMPUTE;
                  r_x_ready   <= 1'b0;
                  r_cell_busy <= 1'b1;
               end
            end
            S_COMPUTE: begin
               r_lat_cnt <= r_lat_cnt - c_lat_one;
               // Cell inputs have now been stable for CELL_LATENCY cycles.
               if (r_lat_cnt == c_lat_one) begin
                  r_h_state   <= cell_h_t;
                  r_step      <= w_step_inc;
                  r_cell_busy <= 1'b0;
                  if (w_step_inc == c_seq_len) begin
                     r_state   <= S_OUTPUT;
                     r_h_valid <= 1'b1;
                  end else begin
                     r_state   <= S_ACCEPT;
                     r_x_ready <= 1'b1;
                  end
               end
            end
            S_OUTPUT: begin
               if (h_ready) begin
                  r_h_state <= '{default: '0};
                  r_step    <= '0;
                  r_state   <= S_ACCEPT;
                  r_h_valid <= 1'b0;
                  r_x_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_ACCEPT;
               r_x_ready   <= 1'b1;
               r_cell_busy <= 1'b0;
               r_h_valid   <= 1'b0;
            end
         endcase
      end
   end

   assign x_ready     = r_x_ready;
   assign cell_busy   = r_cell_busy;
   assign h_valid     = r_h_valid;
   assign cell_x_t    = r_x_reg;
   assign cell_h_prev = r_h_state;
   assign h_data      = r_h_state;
   assign step        = r_step;

endmodule

`default_nettype wire
